avalonmm_arbiter_mux: RTL and testbench
=======================================

Name: avalonmm_arbiter_mux

Overview:
- N-master to 1-slave Avalon-MM arbiter/mux; parametrised successor of the two-master instruction-memory select mux.
- Sits between the imem/dmem masters (CPU, rf_ctrl loader, future DMA) and one memory slave.
- Adds round-robin arbitration, command locking across waitrequest stalls, and a read-tag FIFO so pipelined read responses return to the issuing master.

Parameters:
- NUM_MASTERS, 2, number of Avalon-MM masters (2..8).
- DATA_WIDTH, 32, data width in bits (multiple of 8).
- ADDR_WIDTH, 32, address width in bits.
- MAX_PENDING_READS, 4, read-tag FIFO depth (power of 2, >=1).
- ARB_MODE, 0, 0 = external select, 1 = round-robin.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- select  in  $clog2(NUM_MASTERS)  granted master in ARB_MODE 0; ignored in mode 1.
- m_address  in  [NUM_MASTERS][ADDR_WIDTH]  per-master address.
- m_writedata  in  [NUM_MASTERS][DATA_WIDTH]  per-master write data.
- m_byteenable  in  [NUM_MASTERS][DATA_WIDTH/8]  per-master byte enables.
- m_write / m_read  in  [NUM_MASTERS]  per-master command strobes.
- m_waitrequest  out  [NUM_MASTERS]  per-master stall.
- m_readdata  out  [NUM_MASTERS][DATA_WIDTH]  response data, broadcast to all masters.
- m_readdatavalid  out  [NUM_MASTERS]  one-hot response valid.
- s_address, s_writedata, s_byteenable, s_write, s_read  out  widths as above  slave command.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  DATA_WIDTH  slave read data.
- s_readdatavalid  in  1  slave response valid.
- pending_reads  out  $clog2(MAX_PENDING_READS)+1  outstanding read count.
- rsp_err  out  1  sticky: readdatavalid received with no outstanding read.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low (rst_n).
- Reset values:
  - lock_q = 0; rr_ptr = 0; FIFO empty; pending_reads = 0; rsp_err = 0.
  - During reset, s_read/s_write = 0, m_waitrequest = all 1, m_readdatavalid = 0.
- Requesting master: m_read[i] | m_write[i].
- Arbitration, when lock_q = 0 (combinational, zero-cycle command latency):
  - Mode 0: grant = select.
  - Mode 1: first requester at or after rr_ptr, wrapping modulo NUM_MASTERS.
  - No requester: grant_valid = 0, s_read = s_write = 0.
- Lock:
  - If the granted command is presented and s_waitrequest = 1, set lock_q = 1 and lock_id = grant on the next edge.
  - While locked, grant = lock_id regardless of select or other requests.
  - Clear lock_q on the cycle the command is accepted (s_waitrequest = 0).
- Forwarding: the granted master's address/writedata/byteenable/read/write drive s_*.
  - m_waitrequest[grant] = s_waitrequest, or 1 when read-blocked.
  - Every non-granted master sees m_waitrequest = 1.
- Read blocking: if the FIFO is full, a granted read is not forwarded (s_read = 0) and m_waitrequest[grant] = 1.
  - Full blocks issue even if a pop occurs the same cycle.
  - Writes are never blocked by FIFO state.
- Accepted read (s_read & ~s_waitrequest): push grant id to the FIFO; the pointer wraps modulo depth.
- Mode 1 pointer: rr_ptr <= grant+1 (mod NUM_MASTERS) on any accepted command.
- Response routing:
  - s_readdatavalid pops the FIFO head and sets m_readdatavalid[head] = 1 in the same cycle (combinational).
  - m_readdata = s_readdata to all masters.
- Simultaneous push and pop: both take effect; pending_reads is unchanged.
- s_readdatavalid with an empty FIFO: response dropped, all m_readdatavalid = 0, rsp_err set until reset.
- Writes carry no response and are not tagged.
- Reset mid-operation: FIFO and lock are cleared immediately; late slave responses after reset set rsp_err.

Decomposition:
- Package avalonmm_arb_pkg: enum arb_mode_e {ARB_SELECT=0, ARB_RR=1}; function id_width(n) = max(1, $clog2(n)).
- One sub-module, avalonmm_rd_tag_fifo:
  - Parametrised depth and width; push/pop/full/empty/count.
  - Async active-low reset.

Test Plan:
- Mode 0, NUM_MASTERS=2, select=1, m_write[1] at addr 0x10, data 0xDEADBEEF, s_waitrequest=0 -> same-cycle s_write=1, s_address=0x10; m_waitrequest = 2'b01.
- Mode 1, NUM_MASTERS=3, all masters write continuously with s_waitrequest=0 -> grants cycle 0,1,2,0,1,2; each master accepted once per 3 cycles.
- Lock: master 0 read with s_waitrequest=1 for 3 cycles while select switches to 1 -> grant stays 0 until acceptance; master 1 is then granted on the next cycle.
- Routing: MAX_PENDING_READS=4; reads issued 0,1,0,2 back-to-back; slave returns 0xA,0xB,0xC,0xD at latency 5 -> m_readdatavalid one-hot 0,1,0,2 with matching data; pending_reads peaks at 4.
- Full: 4 reads outstanding, 5th read requested -> s_read=0 and m_waitrequest=1 until the first readdatavalid, then issued the following cycle.
- Error/reset: s_readdatavalid with FIFO empty -> rsp_err=1, no m_readdatavalid; assert rst_n=0 with 2 reads pending -> pending_reads=0, rsp_err=0 immediately.

Source files
------------

// File: rtl/avalonmm_arb_pkg.sv
// Shared types and helpers for the N-master Avalon-MM arbiter/mux.
// Imported by the arbiter top and its read-tag FIFO.
package avalonmm_arb_pkg;

  typedef enum logic {
    ARB_SELECT = 1'b0,
    ARB_RR     = 1'b1
  } arb_mode_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avalonmm_arbiter_mux_if.sv
// Avalon-MM bus bundle with LANES parallel ports.
// master drives the command side, slave returns wait/response.
interface avalonmm_arbiter_mux_if #(
  parameter int LANES      = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [LANES-1:0][ADDR_WIDTH-1:0]   address;
  logic [LANES-1:0][DATA_WIDTH-1:0]   writedata;
  logic [LANES-1:0][DATA_WIDTH/8-1:0] byteenable;
  logic [LANES-1:0]                   write;
  logic [LANES-1:0]                   read;
  logic [LANES-1:0]                   waitrequest;
  logic [LANES-1:0][DATA_WIDTH-1:0]   readdata;
  logic [LANES-1:0]                   readdatavalid;

  modport master (
    output address,
    output writedata,
    output byteenable,
    output write,
    output read,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  writedata,
    input  byteenable,
    input  write,
    input  read,
    output waitrequest,
    output readdata,
    output readdatavalid
  );

endinterface

// File: rtl/avalonmm_rd_tag_fifo.sv
// Read-tag FIFO: remembers which master issued each pending read.
// Push is ignored when full, pop is ignored when empty.
module avalonmm_rd_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        push_data_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = bump(wr_ptr_q);
    if (do_pop)  rd_ptr_d = bump(rd_ptr_q);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/avalonmm_arbiter_mux.sv
// N-master to 1-slave Avalon-MM arbiter/mux with command lock
// across stalls and tagged routing of pipelined read responses.
module avalonmm_arbiter_mux
  import avalonmm_arb_pkg::*;
#(
  parameter int NUM_MASTERS       = 2,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int MAX_PENDING_READS = 4,
  parameter int ARB_MODE          = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [id_width(NUM_MASTERS)-1:0]    select,
  avalonmm_arbiter_mux_if.slave               m_bus,
  avalonmm_arbiter_mux_if.master              s_bus,
  output logic [$clog2(MAX_PENDING_READS):0]  pending_reads,
  output logic                                rsp_err
);

  localparam int IDW = id_width(NUM_MASTERS);
  localparam int CW  = $clog2(MAX_PENDING_READS) + 1;

  typedef logic [IDW-1:0] id_t;

  logic [NUM_MASTERS-1:0] req;
  logic [(1<<IDW)-1:0]    req_ext;
  id_t                    rr_ptr_q, rr_ptr_d;
  id_t                    lock_id_q, lock_id_d;
  id_t                    rr_id, cand, grant, head;
  logic                   lock_q, lock_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   rr_found, grant_valid;
  logic                   sel_read, sel_write;
  logic                   rd_block, fwd_read, fwd_write;
  logic                   s_wait, accept, push, pop;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count;

  assign req    = m_bus.read | m_bus.write;
  assign s_wait = s_bus.waitrequest[0];

  always_comb begin
    req_ext = '0;
    req_ext[NUM_MASTERS-1:0] = req;
  end

  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    cand     = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = id_t'((int'(rr_ptr_q) + k) % NUM_MASTERS);
      if (!rr_found && req_ext[cand]) begin
        rr_found = 1'b1;
        rr_id    = cand;
      end
    end
  end

  // A stalled command keeps the bus until the slave takes it.
  always_comb begin
    grant       = select;
    grant_valid = req_ext[select];
    if (lock_q) begin
      grant       = lock_id_q;
      grant_valid = 1'b1;
    end else if (ARB_MODE == int'(ARB_RR)) begin
      grant       = rr_id;
      grant_valid = rr_found;
    end
    if (!rst_n) grant_valid = 1'b0;
  end

  always_comb begin
    s_bus.address    = '0;
    s_bus.writedata  = '0;
    s_bus.byteenable = '0;
    sel_read         = 1'b0;
    sel_write        = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_valid && grant == id_t'(i)) begin
        s_bus.address[0]    = m_bus.address[i];
        s_bus.writedata[0]  = m_bus.writedata[i];
        s_bus.byteenable[0] = m_bus.byteenable[i];
        sel_read            = m_bus.read[i];
        sel_write           = m_bus.write[i];
      end
    end
  end

  // Full blocks new reads even when a response pops this cycle.
  assign rd_block    = sel_read & fifo_full;
  assign fwd_read    = sel_read & ~fifo_full;
  assign fwd_write   = sel_write;
  assign s_bus.read  = fwd_read;
  assign s_bus.write = fwd_write;

  assign accept = (fwd_read | fwd_write) & ~s_wait;
  assign push   = fwd_read & ~s_wait;
  assign pop    = s_bus.readdatavalid[0] & ~fifo_empty;

  always_comb begin
    m_bus.waitrequest   = '1;
    m_bus.readdatavalid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_valid && grant == id_t'(i))
        m_bus.waitrequest[i] = s_wait | rd_block;
      if (pop && head == id_t'(i))
        m_bus.readdatavalid[i] = 1'b1;
    end
  end

  assign m_bus.readdata = {NUM_MASTERS{s_bus.readdata[0]}};

  always_comb begin
    lock_d    = 1'b0;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    rsp_err_d = rsp_err_q | (s_bus.readdatavalid[0] & fifo_empty);
    if ((fwd_read | fwd_write) && s_wait) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
    if (accept) begin
      rr_ptr_d = (grant == id_t'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  avalonmm_rd_tag_fifo #(
    .DEPTH (MAX_PENDING_READS),
    .WIDTH (IDW)
  ) u_rd_tags (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (grant),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign pending_reads = fifo_count;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_avalonmm_arbiter_mux.sv
// Directed bench: dut0 is 2 masters / external select,
// dut1 is 3 masters / round-robin; both keep 4 pending reads.
module tb_avalonmm_arbiter_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [0:0] sel0;
  logic [1:0] sel1;
  logic [2:0] pend0, pend1;
  logic err0, err1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  avalonmm_arbiter_mux_if #(.LANES(2)) m0 ();
  avalonmm_arbiter_mux_if #(.LANES(1)) s0 ();
  avalonmm_arbiter_mux_if #(.LANES(3)) m1 ();
  avalonmm_arbiter_mux_if #(.LANES(1)) s1 ();

  avalonmm_arbiter_mux #(
    .NUM_MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .MAX_PENDING_READS(4), .ARB_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .select(sel0),
    .m_bus(m0), .s_bus(s0),
    .pending_reads(pend0), .rsp_err(err0)
  );

  avalonmm_arbiter_mux #(
    .NUM_MASTERS(3), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .MAX_PENDING_READS(4), .ARB_MODE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .select(sel1),
    .m_bus(m1), .s_bus(s1),
    .pending_reads(pend1), .rsp_err(err1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sel0 = '0; sel1 = '0;
    m0.address = '0; m0.writedata = '0; m0.byteenable = '0;
    m0.read = '0; m0.write = '0;
    m1.address = '0; m1.writedata = '0; m1.byteenable = '0;
    m1.read = '0; m1.write = '0;
    s0.waitrequest = '0; s0.readdata = '0; s0.readdatavalid = '0;
    s1.waitrequest = '0; s1.readdata = '0; s1.readdatavalid = '0;
  endtask

  task automatic test_reset();
    idle();
    m0.read[0] = 1'b1;
    m1.write = 3'b111;
    s1.readdatavalid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++; if (s0.read !== 1'b0) begin bad++;
      $display("FAIL rst_sread got=%0h exp=0", s0.read); end
    total++; if (s1.write !== 1'b0) begin bad++;
      $display("FAIL rst_swrite got=%0h exp=0", s1.write); end
    total++; if (m0.waitrequest !== 2'b11) begin bad++;
      $display("FAIL rst_wait0 got=%0h exp=3", m0.waitrequest); end
    total++; if (m1.waitrequest !== 3'b111) begin bad++;
      $display("FAIL rst_wait1 got=%0h exp=7", m1.waitrequest); end
    total++; if (m1.readdatavalid !== 3'b000) begin bad++;
      $display("FAIL rst_rdv got=%0h exp=0", m1.readdatavalid); end
    total++; if (pend0 !== 3'd0 || pend1 !== 3'd0) begin bad++;
      $display("FAIL rst_pend got=%0d/%0d exp=0", pend0, pend1); end
    total++; if (err0 !== 1'b0 || err1 !== 1'b0) begin bad++;
      $display("FAIL rst_err got=%0b/%0b exp=0", err0, err1); end
    step();
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_mode0_write();
    step();
    sel0 = 1'b1;
    m0.write[1] = 1'b1;
    m0.address[1] = 32'h10;
    m0.writedata[1] = 32'hDEADBEEF;
    m0.byteenable[1] = 4'hF;
    #1;
    total++; if (s0.write !== 1'b1 || s0.read !== 1'b0) begin bad++;
      $display("FAIL m0_cmd got=w%0b r%0b exp=w1 r0", s0.write, s0.read); end
    total++; if (s0.address[0] !== 32'h10) begin bad++;
      $display("FAIL m0_addr got=%0h exp=10", s0.address[0]); end
    total++; if (s0.writedata[0] !== 32'hDEADBEEF) begin bad++;
      $display("FAIL m0_wdata got=%0h exp=deadbeef", s0.writedata[0]); end
    total++; if (s0.byteenable[0] !== 4'hF) begin bad++;
      $display("FAIL m0_be got=%0h exp=f", s0.byteenable[0]); end
    total++; if (m0.waitrequest !== 2'b01) begin bad++;
      $display("FAIL m0_wait got=%0b exp=01", m0.waitrequest); end
    step();
    sel0 = 1'b0;
    #1;
    total++; if (s0.write !== 1'b0) begin bad++;
      $display("FAIL m0_nogrant got=%0b exp=0", s0.write); end
    total++; if (m0.waitrequest !== 2'b11) begin bad++;
      $display("FAIL m0_nogrant_wait got=%0b exp=11", m0.waitrequest); end
    idle();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_w;
    int g;
    step();
    m1.write = 3'b111;
    for (int i = 0; i < 3; i++) m1.address[i] = 32'h100 + i;
    for (int c = 0; c < 6; c++) begin
      #1;
      g = c % 3;
      exp_w = ~(3'b001 << g);
      total++; if (s1.address[0] !== 32'h100 + g) begin bad++;
        $display("FAIL rr_addr c=%0d got=%0h exp=%0h", c, s1.address[0], 32'h100 + g); end
      total++; if (m1.waitrequest !== exp_w) begin bad++;
        $display("FAIL rr_wait c=%0d got=%0b exp=%0b", c, m1.waitrequest, exp_w); end
      step();
    end
    m1.write = 3'b101;
    #1;
    total++; if (s1.address[0] !== 32'h100 || m1.waitrequest !== 3'b110) begin bad++;
      $display("FAIL rr_skip0 got=%0h/%0b exp=100/110", s1.address[0], m1.waitrequest); end
    step();
    #1;
    total++; if (s1.address[0] !== 32'h102 || m1.waitrequest !== 3'b011) begin bad++;
      $display("FAIL rr_skip2 got=%0h/%0b exp=102/011", s1.address[0], m1.waitrequest); end
    idle();
  endtask

  task automatic test_lock();
    step();
    sel0 = 1'b0;
    m0.read[0] = 1'b1; m0.address[0] = 32'h20;
    m0.write[1] = 1'b1; m0.address[1] = 32'h30;
    s0.waitrequest = 1'b1;
    #1;
    total++; if (s0.read !== 1'b1 || s0.address[0] !== 32'h20) begin bad++;
      $display("FAIL lk_first got=r%0b %0h exp=r1 20", s0.read, s0.address[0]); end
    total++; if (m0.waitrequest !== 2'b11) begin bad++;
      $display("FAIL lk_stall got=%0b exp=11", m0.waitrequest); end
    for (int c = 0; c < 2; c++) begin
      step();
      sel0 = 1'b1;
      #1;
      total++; if (s0.read !== 1'b1 || s0.write !== 1'b0 || s0.address[0] !== 32'h20) begin
        bad++;
        $display("FAIL lk_hold c=%0d got=r%0b w%0b %0h exp=r1 w0 20",
                 c, s0.read, s0.write, s0.address[0]);
      end
    end
    step();
    s0.waitrequest = 1'b0;
    #1;
    total++; if (s0.read !== 1'b1 || m0.waitrequest !== 2'b10) begin bad++;
      $display("FAIL lk_accept got=r%0b %0b exp=r1 10", s0.read, m0.waitrequest); end
    step();
    m0.read[0] = 1'b0;
    #1;
    total++; if (s0.write !== 1'b1 || s0.address[0] !== 32'h30) begin bad++;
      $display("FAIL lk_next got=w%0b %0h exp=w1 30", s0.write, s0.address[0]); end
    total++; if (m0.waitrequest !== 2'b01 || pend0 !== 3'd1) begin bad++;
      $display("FAIL lk_next_wait got=%0b p%0d exp=01 p1", m0.waitrequest, pend0); end
    step();
    m0.write[1] = 1'b0;
    s0.readdatavalid = 1'b1;
    s0.readdata = 32'h55;
    #1;
    total++; if (m0.readdatavalid !== 2'b01 || m0.readdata[1] !== 32'h55) begin bad++;
      $display("FAIL lk_rsp got=%0b %0h exp=01 55", m0.readdatavalid, m0.readdata[1]); end
    step();
    idle();
    #1;
    total++; if (pend0 !== 3'd0 || err0 !== 1'b0) begin bad++;
      $display("FAIL lk_drain got=p%0d e%0b exp=p0 e0", pend0, err0); end
  endtask

  task automatic test_routing();
    logic [1:0]  issue_m [4];
    logic [31:0] rsp [4];
    logic [2:0]  exp_v [4];
    issue_m = '{2'd0, 2'd1, 2'd0, 2'd2};
    rsp     = '{32'hA, 32'hB, 32'hC, 32'hD};
    exp_v   = '{3'b001, 3'b010, 3'b001, 3'b100};
    step();
    for (int c = 0; c < 10; c++) begin
      m1.read = '0;
      s1.readdatavalid = 1'b0;
      if (c < 4) begin
        m1.read[issue_m[c]] = 1'b1;
        m1.address[issue_m[c]] = 32'h200 + c;
      end
      if (c >= 5 && c < 9) begin
        s1.readdatavalid = 1'b1;
        s1.readdata = rsp[c-5];
      end
      #1;
      if (c < 4) begin
        total++; if (s1.read !== 1'b1 || s1.address[0] !== 32'h200 + c) begin bad++;
          $display("FAIL rt_issue c=%0d got=r%0b %0h exp=r1 %0h",
                   c, s1.read, s1.address[0], 32'h200 + c);
        end
        total++; if (pend1 !== 3'(c)) begin bad++;
          $display("FAIL rt_pend c=%0d got=%0d exp=%0d", c, pend1, c); end
      end
      if (c == 4) begin
        total++; if (pend1 !== 3'd4) begin bad++;
          $display("FAIL rt_peak got=%0d exp=4", pend1); end
      end
      if (c >= 5 && c < 9) begin
        total++; if (m1.readdatavalid !== exp_v[c-5]) begin bad++;
          $display("FAIL rt_valid c=%0d got=%0b exp=%0b", c, m1.readdatavalid, exp_v[c-5]); end
        total++; if (m1.readdata[0] !== rsp[c-5]) begin bad++;
          $display("FAIL rt_data c=%0d got=%0h exp=%0h", c, m1.readdata[0], rsp[c-5]); end
      end
      if (c == 9) begin
        total++; if (m1.readdatavalid !== 3'b000 || pend1 !== 3'd0) begin bad++;
          $display("FAIL rt_done got=%0b p%0d exp=000 p0", m1.readdatavalid, pend1); end
      end
      step();
    end
    idle();
  endtask

  task automatic test_full();
    for (int c = 0; c < 14; c++) begin
      m1.read = '0;
      s1.readdatavalid = 1'b0;
      if (c < 8) begin
        m1.read[1] = 1'b1;
        m1.address[1] = 32'h40 + ((c < 4) ? c : 4);
      end
      if (c == 6 || (c >= 9 && c < 13)) begin
        s1.readdatavalid = 1'b1;
        s1.readdata = 32'h77;
      end
      #1;
      if (c >= 4 && c < 7) begin
        total++; if (s1.read !== 1'b0 || m1.waitrequest !== 3'b111) begin bad++;
          $display("FAIL fl_block c=%0d got=r%0b %0b exp=r0 111", c, s1.read, m1.waitrequest); end
      end
      if (c == 6) begin
        total++; if (m1.readdatavalid !== 3'b010) begin bad++;
          $display("FAIL fl_pop got=%0b exp=010", m1.readdatavalid); end
      end
      if (c == 7) begin
        total++; if (s1.read !== 1'b1 || s1.address[0] !== 32'h44) begin bad++;
          $display("FAIL fl_issue got=r%0b %0h exp=r1 44", s1.read, s1.address[0]); end
        total++; if (m1.waitrequest !== 3'b101 || pend1 !== 3'd3) begin bad++;
          $display("FAIL fl_issue_wait got=%0b p%0d exp=101 p3", m1.waitrequest, pend1); end
      end
      if (c == 8) begin
        total++; if (pend1 !== 3'd4) begin bad++;
          $display("FAIL fl_refill got=%0d exp=4", pend1); end
      end
      if (c == 13) begin
        total++; if (pend1 !== 3'd0) begin bad++;
          $display("FAIL fl_drain got=%0d exp=0", pend1); end
      end
      step();
    end
    idle();
  endtask

  task automatic test_error();
    step();
    s1.readdatavalid = 1'b1;
    s1.readdata = 32'h99;
    #1;
    total++; if (m1.readdatavalid !== 3'b000 || err1 !== 1'b0) begin bad++;
      $display("FAIL er_drop got=%0b e%0b exp=000 e0", m1.readdatavalid, err1); end
    step();
    s1.readdatavalid = 1'b0;
    #1;
    total++; if (err1 !== 1'b1 || pend1 !== 3'd0) begin bad++;
      $display("FAIL er_set got=e%0b p%0d exp=e1 p0", err1, pend1); end
    step();
    #1;
    total++; if (err1 !== 1'b1) begin bad++;
      $display("FAIL er_sticky got=%0b exp=1", err1); end
  endtask

  task automatic test_reset_mid();
    step();
    sel0 = 1'b0;
    m0.read[0] = 1'b1;
    m0.address[0] = 32'h60;
    step();
    step();
    s0.waitrequest = 1'b1;
    #1;
    total++; if (pend0 !== 3'd2) begin bad++;
      $display("FAIL rm_pend got=%0d exp=2", pend0); end
    rst_n = 1'b0;
    #1;
    total++; if (pend0 !== 3'd0 || err1 !== 1'b0) begin bad++;
      $display("FAIL rm_clear got=p%0d e%0b exp=p0 e0", pend0, err1); end
    total++; if (s0.read !== 1'b0 || m0.waitrequest !== 2'b11) begin bad++;
      $display("FAIL rm_quiet got=r%0b %0b exp=r0 11", s0.read, m0.waitrequest); end
    step();
    idle();
    rst_n = 1'b1;
    s0.readdatavalid = 1'b1;
    s0.readdata = 32'h1234;
    #1;
    total++; if (m0.readdatavalid !== 2'b00) begin bad++;
      $display("FAIL rm_late got=%0b exp=00", m0.readdatavalid); end
    step();
    s0.readdatavalid = 1'b0;
    #1;
    total++; if (err0 !== 1'b1) begin bad++;
      $display("FAIL rm_err got=%0b exp=1", err0); end
  endtask

  initial begin
    test_reset();
    test_mode0_write();
    test_round_robin();
    test_lock();
    test_routing();
    test_full();
    test_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
